// File: rtl/cpu_v1_if.sv
// Program-load and status bundle of the cpu_v1 core.
// The bench drives the master side and the core is the slave side.
interface cpu_v1_if;
  logic        prog_we;
  logic [6:0]  prog_addr;
  logic [15:0] prog_data;
  logic [6:0]  pc;
  logic [15:0] inst;
  logic        fetch;
  logic [2:0]  flags;

  modport master (output prog_we, prog_addr, prog_data,
                  input  pc, inst, fetch, flags);
  modport slave  (input  prog_we, prog_addr, prog_data,
                  output pc, inst, fetch, flags);
endinterface

// File: rtl/cpu_v1.sv
// Two-phase 8-bit CPU: fetch one 16-bit word, then execute it.
// Holds a 16x8 register file, an 8-bit ALU and a unified 128x16 memory.
module cpu_v1 (
  input logic       clk,
  input logic       rst,
  cpu_v1_if.slave   bus
);
  logic [15:0] mem [128];
  logic [7:0]  regs [16];
  logic [6:0]  pc_p0;
  logic [15:0] inst_p0;
  logic        fetch_p0;
  logic [2:0]  flags_p0;

  logic [3:0]  op, rd, rs1, rs2;
  logic [7:0]  imm, a, b;
  logic [15:0] word;
  logic [7:0]  ld_byte;
  logic [15:0] st_word;
  logic [8:0]  alu_out;
  logic        is_alu, reg_we, mem_we;
  logic [7:0]  wdata;

  // Returns {carry, result}; carry means "no borrow" for subtract-style ops.
  function automatic logic [8:0] alu(input logic [3:0] f, input logic [7:0] x,
                                     input logic [7:0] y);
    logic [8:0] r;
    r = 9'd0;
    case (f)
      4'h0: r = {1'b0, x} + {1'b0, y};
      4'h1: r = {(x >= y), x - y};
      4'h2: r = {1'b0, x & y};
      4'h3: r = {1'b0, x | y};
      4'h4: r = {1'b0, x ^ y};
      4'h5: r = {1'b0, ~x};
      4'h6: r = {x[7], x[6:0], 1'b0};
      4'h7: r = {x[0], 1'b0, x[7:1]};
      4'h8: r = {1'b0, x};
      4'h9: r = {1'b0, x} + 9'd1;
      4'hA: r = {(x != 8'd0), x - 8'd1};
      4'hB: r = {(x == 8'd0), 8'd0 - x};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  assign op  = inst_p0[15:12];
  assign rd  = inst_p0[11:8];
  assign rs1 = inst_p0[7:4];
  assign rs2 = inst_p0[3:0];
  assign imm = inst_p0[7:0];
  assign a   = regs[rs1];
  assign b   = regs[rs2];

  // Byte address A: word A>>1, odd address selects the high byte.
  assign word    = mem[a[7:1]];
  assign ld_byte = a[0] ? word[15:8] : word[7:0];
  assign st_word = a[0] ? {b, word[7:0]} : {word[15:8], b};

  assign alu_out = alu(op, a, b);
  assign is_alu  = (op <= 4'hB);
  assign mem_we  = !fetch_p0 && (op == 4'hD);
  assign reg_we  = !fetch_p0 && (is_alu || op == 4'hC || op == 4'hF);

  always_comb begin
    wdata = alu_out[7:0];
    if (op == 4'hC) wdata = ld_byte;
    else if (op == 4'hF) wdata = imm;
  end

  // ---- memory: program load under reset, CPU stores otherwise ----
  always_ff @(posedge clk) begin
    if (rst) begin
      if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    end else if (mem_we) begin
      mem[a[7:1]] <= st_word;
    end
  end

  // ---- register file ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else if (reg_we) begin
      regs[rd] <= wdata;
    end
  end

  // ---- fetch/execute sequencing and flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= 7'd0;
      inst_p0  <= 16'h0000;
      fetch_p0 <= 1'b1;
      flags_p0 <= 3'b000;
    end else if (fetch_p0) begin
      inst_p0  <= mem[pc_p0];
      pc_p0    <= pc_p0 + 7'd1;
      fetch_p0 <= 1'b0;
    end else begin
      fetch_p0 <= 1'b1;
      if (is_alu) flags_p0 <= {alu_out[8], alu_out[7], (alu_out[7:0] == 8'd0)};
    end
  end

  assign bus.pc    = pc_p0;
  assign bus.inst  = inst_p0;
  assign bus.fetch = fetch_p0;
  assign bus.flags = flags_p0;
endmodule

// File: tb/tb_cpu_v1.sv
// Scoreboard bench for cpu_v1: each loaded instruction queues its expected
// commit; a monitor pops and compares whenever an execute cycle completes.
module tb_cpu_v1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cpu_v1_if bus ();

  cpu_v1 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  pc;
    logic [15:0] inst;
    logic [2:0]  flags;
    int          ridx;
    logic [7:0]  rval;
    int          midx;
    logic [15:0] mval;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_fetch = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a 0->1 transition of fetch out of reset marks a committed instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.fetch && !prev_fetch) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got pc 0x%0h, expected no commit", bus.pc);
      end else begin
        e = sbq.pop_front();
        chk("pc", {25'd0, bus.pc}, {25'd0, e.pc});
        chk("inst", {16'd0, bus.inst}, {16'd0, e.inst});
        chk("flags", {29'd0, bus.flags}, {29'd0, e.flags});
        if (e.ridx >= 0) chk($sformatf("r%0d", e.ridx), {24'd0, dut.regs[e.ridx]}, {24'd0, e.rval});
        if (e.midx >= 0) chk($sformatf("mem[%0d]", e.midx), {16'd0, dut.mem[e.midx]}, {16'd0, e.mval});
      end
    end
    prev_fetch = rst ? 1'b1 : bus.fetch;
  end

  task automatic load(input int addr, input logic [15:0] w);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[6:0];
    bus.prog_data = w;
    @(posedge clk);
    #1 bus.prog_we = 1'b0;
  endtask

  task automatic expect_c(input int a, input logic [15:0] w, input logic [2:0] fl,
                          input int ri, input logic [7:0] rv,
                          input int mi = -1, input logic [15:0] mv = 16'h0);
    exp_t e;
    logic [6:0] p;
    p = a[6:0] + 7'd1;
    e.pc = p; e.inst = w; e.flags = fl;
    e.ridx = ri; e.rval = rv; e.midx = mi; e.mval = mv;
    sbq.push_back(e);
  endtask

  task automatic ins(input int a, input logic [15:0] w, input logic [2:0] fl,
                     input int ri, input logic [7:0] rv,
                     input int mi = -1, input logic [15:0] mv = 16'h0);
    load(a, w);
    expect_c(a, w, fl, ri, rv, mi, mv);
  endtask

  // Release reset for n instructions, then stop the core again with reset.
  task automatic run(input int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    sbq.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.regs[i] !== 8'd0) nz++;
    chk({tag, "_pc"}, {25'd0, bus.pc}, 32'd0);
    chk({tag, "_inst"}, {16'd0, bus.inst}, 32'd0);
    chk({tag, "_fetch"}, {31'd0, bus.fetch}, 32'd1);
    chk({tag, "_flags"}, {29'd0, bus.flags}, 32'd0);
    chk({tag, "_regs_nonzero"}, nz, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish within 100000 ns");
    $fatal(1);
  end

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = 7'd0; bus.prog_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");

    // Basic LDI/LDI/ADD sequence
    ins(0, 16'hF10A, 3'b000, 1, 8'h0A);
    ins(1, 16'hF202, 3'b000, 2, 8'h02);
    ins(2, 16'h0312, 3'b000, 3, 8'h0C);
    run(3);
    chk_reset_state("rerst1");

    // Every ALU opcode with its flag behaviour ({carry, negative, zero})
    ins(0,  16'hF1FF, 3'b000, 1,  8'hFF);
    ins(1,  16'hF201, 3'b000, 2,  8'h01);
    ins(2,  16'h0312, 3'b101, 3,  8'h00);
    ins(3,  16'hF401, 3'b101, 4,  8'h01);
    ins(4,  16'hF502, 3'b101, 5,  8'h02);
    ins(5,  16'h1645, 3'b010, 6,  8'hFF);
    ins(6,  16'h2715, 3'b000, 7,  8'h02);
    ins(7,  16'h3845, 3'b000, 8,  8'h03);
    ins(8,  16'h4912, 3'b010, 9,  8'hFE);
    ins(9,  16'h5A10, 3'b001, 10, 8'h00);
    ins(10, 16'h6B10, 3'b110, 11, 8'hFE);
    ins(11, 16'h7C40, 3'b101, 12, 8'h00);
    ins(12, 16'h8D20, 3'b000, 13, 8'h01);
    ins(13, 16'h9E10, 3'b101, 14, 8'h00);
    ins(14, 16'hAF40, 3'b101, 15, 8'h00);
    ins(15, 16'hB050, 3'b010, 0,  8'hFE);
    ins(16, 16'hB130, 3'b101, 1,  8'h00);
    run(17);

    // Byte store/load with read-merge-write, then flag persistence
    load(32, 16'h1234);
    ins(0,  16'hF141, 3'b000, 1, 8'h41);
    ins(1,  16'hF2AB, 3'b000, 2, 8'hAB);
    ins(2,  16'hD012, 3'b000, 0, 8'h00, 32, 16'hAB34);
    ins(3,  16'hF140, 3'b000, 1, 8'h40);
    ins(4,  16'hF2CD, 3'b000, 2, 8'hCD);
    ins(5,  16'hD012, 3'b000, 0, 8'h00, 32, 16'hABCD);
    ins(6,  16'hF141, 3'b000, 1, 8'h41);
    ins(7,  16'hC510, 3'b000, 5, 8'hAB);
    ins(8,  16'h1311, 3'b101, 3, 8'h00);
    ins(9,  16'hF7AA, 3'b101, 7, 8'hAA);
    ins(10, 16'hC610, 3'b101, 6, 8'hAB);
    ins(11, 16'hD912, 3'b101, 9, 8'h00, 32, 16'hCDCD);
    ins(12, 16'hE000, 3'b101, -1, 8'h00);
    run(13);

    // PC wrap: word 0 is an LDI, the rest NOPs; word 0 must execute again
    load(0, 16'hF355);
    for (int i = 1; i < 128; i++) load(i, 16'hE000);
    for (int i = 0; i < 129; i++) begin
      if (i % 128 == 0) expect_c(i % 128, 16'hF355, 3'b000, 3, 8'h55);
      else              expect_c(i % 128, 16'hE000, 3'b000, -1, 8'h00);
    end
    run(129);

    // Reset during the execute cycle of LDI r4 aborts the write
    load(0, 16'hF455);
    load(1, 16'hF101);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_r4", {24'd0, dut.regs[4]}, 32'd0);
    chk_reset_state("midrst");
    chk("mem0_retained", {16'd0, dut.mem[0]}, 32'h0000F455);
    expect_c(0, 16'hF455, 3'b000, 4, 8'h55);
    expect_c(1, 16'hF101, 3'b000, 1, 8'h01);
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
